seq_smod: RTL and testbench

- Multi-cycle signed modulo unit with a start/done handshake.
- Sequential counterpart to the single-cycle SMOD datapath component: same operand and result semantics, one quotient bit per cycle.
- Used by the scheduled (FSM + datapath) netlists, where the controller issues an operation and waits for done instead of budgeting a full combinational divide in one cycle.

---
 rtl/seq_smod.sv | 199 +++++++++++++++++++
 tb/tb_seq_smod.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_smod.sv
// ---------------------------------------------------------------------------
// seq_smod : multi-cycle signed modulo unit with start/done handshake.
//
// Restoring shift-subtract on operand magnitudes, one quotient bit per
// cycle, then the dividend's sign is applied to the remainder (truncating
// remainder, same as the % operator on signed operands).
//
// Timeline: the accept edge, then DATAWIDTH DIV cycles, one FIX cycle and
// one DONE cycle. busy is high in DIV and FIX, and done pulses in DONE.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   start  request, sampled only in IDLE
//   a, b   signed dividend / divisor, sampled with an accepted start
//   busy   operation in progress (DIV and FIX)
//   done   one-cycle pulse, r/dz (and q) valid
//   r      signed remainder, held until the next FIX
//   dz     divide-by-zero flag belonging to r
//   q      signed quotient (only when SEQ_SMOD_QUOT_EN is defined)
//
// Optional feature macro: SEQ_SMOD_QUOT_EN (adds the quotient output q).
// ---------------------------------------------------------------------------
module seq_smod #(
  parameter int DATAWIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] r,
  output logic                 dz
`ifdef SEQ_SMOD_QUOT_EN
  ,
  output logic [DATAWIDTH-1:0] q
`endif
);

  localparam int CW = $clog2(DATAWIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATAWIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] dvd_q, dvd_d;
  logic [DATAWIDTH-1:0] dsr_q, dsr_d;
  logic [DATAWIDTH-1:0] rem_q, rem_d;
  logic [DATAWIDTH-1:0] r_q, r_d;
  logic                 signA_q, signA_d;
  logic                 dz_q, dz_d;
`ifdef SEQ_SMOD_QUOT_EN
  logic [DATAWIDTH-1:0] quot_q, quot_d;
  logic [DATAWIDTH-1:0] qOut_q, qOut_d;
  logic                 signB_q, signB_d;
`endif

  // The largest magnitude is 2^(DATAWIDTH-1), i.e. the most-negative
  // operand. It fits an unsigned DATAWIDTH-bit value, so the sign bit of
  // a DATAWIDTH+1-bit magnitude is always zero and is not carried.
  logic [DATAWIDTH-1:0] aMag, bMag;
  assign aMag = a[DATAWIDTH-1] ? -a : a;
  assign bMag = b[DATAWIDTH-1] ? -b : b;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. The trial value needs
  // one extra bit. The difference always fits back into DATAWIDTH bits
  // because the partial remainder stays below the divisor, except when
  // b=0, where it accumulates |a| unchanged.
  logic [DATAWIDTH:0]   trial;
  logic                 fits;
  logic [DATAWIDTH-1:0] remStep;
  assign trial   = {rem_q, dvd_q[DATAWIDTH-1]};
  assign fits    = (trial >= {1'b0, dsr_q});
  assign remStep = fits ? (trial[DATAWIDTH-1:0] - dsr_q) : trial[DATAWIDTH-1:0];

  // State and datapath registers. All of them clear on reset, which also
  // aborts any operation in flight without producing a done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      r_q     <= '0;
      signA_q <= 1'b0;
      dz_q    <= 1'b0;
`ifdef SEQ_SMOD_QUOT_EN
      quot_q  <= '0;
      qOut_q  <= '0;
      signB_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      r_q     <= r_d;
      signA_q <= signA_d;
      dz_q    <= dz_d;
`ifdef SEQ_SMOD_QUOT_EN
      quot_q  <= quot_d;
      qOut_q  <= qOut_d;
      signB_q <= signB_d;
`endif
    end
  end

  // Next-state and output logic. start is looked at only in IDLE, so a
  // request during DIV/FIX/DONE is dropped rather than queued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    r_d     = r_q;
    signA_d = signA_q;
    dz_d    = dz_q;
`ifdef SEQ_SMOD_QUOT_EN
    quot_d  = quot_q;
    qOut_d  = qOut_q;
    signB_d = signB_q;
`endif
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          signA_d = a[DATAWIDTH-1];
          dvd_d   = aMag;
          dsr_d   = bMag;
          rem_d   = '0;
          cnt_d   = '0;
`ifdef SEQ_SMOD_QUOT_EN
          signB_d = b[DATAWIDTH-1];
          quot_d  = '0;
`endif
          state_d = S_DIV;
        end
      end

      S_DIV: begin
        busy  = 1'b1;
        rem_d = remStep;
        dvd_d = {dvd_q[DATAWIDTH-2:0], 1'b0};
`ifdef SEQ_SMOD_QUOT_EN
        quot_d = {quot_q[DATAWIDTH-2:0], fits};
`endif
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        busy = 1'b1;
        // A zero divisor leaves rem = |a|, so restoring the sign yields a.
        r_d  = signA_q ? -rem_q : rem_q;
        dz_d = (dsr_q == '0);
`ifdef SEQ_SMOD_QUOT_EN
        if (dsr_q == '0) begin
          qOut_d = '1;
        end else begin
          qOut_d = (signA_q ^ signB_q) ? -quot_q : quot_q;
        end
`endif
        state_d = S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign r  = r_q;
  assign dz = dz_q;
`ifdef SEQ_SMOD_QUOT_EN
  assign q  = qOut_q;
`endif

endmodule

// File: tb/tb_seq_smod.sv
// ---------------------------------------------------------------------------
// tb_seq_smod : scoreboard bench for seq_smod at DATAWIDTH=64.
//
// The driver pushes the expected result of every accepted request (from a
// plain signed %,/ reference) into a queue. A negedge monitor pops and
// compares whenever done is seen, and also checks busy while a request is
// in flight. Define SEQ_SMOD_QUOT_EN to connect and check q as well.
// ---------------------------------------------------------------------------
module tb_seq_smod;

  localparam int DW = 64;
  localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] r;
  logic          dz;
`ifdef SEQ_SMOD_QUOT_EN
  logic [DW-1:0] q;
`endif

  seq_smod #(.DATAWIDTH(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .r    (r),
    .dz   (dz)
`ifdef SEQ_SMOD_QUOT_EN
    ,
    .q    (q)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] r;
    logic          dz;
    logic [DW-1:0] q;
    int            startCycle;
    int            doneAt;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  int            cycleCount = 0;
  int            doneCount = 0;
  logic [DW-1:0] lastR = '0;
  logic          lastDz = 1'b0;

  // Free-running cycle index; driver reads it #1 after the edge, the
  // monitor reads it on the falling edge.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, $signed(act), act, $signed(exp), exp, cycleCount);
    end
  endtask

  // Reference: truncating signed division rules written directly.
  function automatic exp_t refModel(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                    input int sc);
    exp_t e;
    logic signed [DW-1:0] sx, sy;
    sx = x;
    sy = y;
    e.startCycle = sc;
    e.doneAt     = sc + DW + 2;
    if (y == '0) begin
      e.r = x; e.dz = 1'b1; e.q = '1;
    end else if (y == '1) begin
      e.r = '0; e.dz = 1'b0; e.q = -x;
    end else begin
      e.r = sx % sy; e.dz = 1'b0; e.q = sx / sy;
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] randOperand();
    logic [DW-1:0] t;
    case ($urandom_range(0, 9))
      0: t = '0;
      1: t = DW'(1);
      2: t = '1;
      3: t = MINV;
      4: t = MAXV;
      5: begin
        t = DW'($urandom_range(0, 200));
        t = t - DW'(100);
      end
      6: t = {{32{1'b0}}, $urandom} ^ {64{$urandom_range(0, 1) == 1}};
      default: t = {$urandom, $urandom};
    endcase
    return t;
  endfunction

  // Monitor: compare on every done, check busy while a request is pending.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", DW'(done), '0);
        end else begin
          e = sb.pop_front();
          checkOutput("latency", DW'(cycleCount), DW'(e.doneAt));
          checkOutput("r", r, e.r);
          checkOutput("dz", DW'(dz), DW'(e.dz));
          checkOutput("busy_in_done", DW'(busy), '0);
`ifdef SEQ_SMOD_QUOT_EN
          checkOutput("q", q, e.q);
`endif
          lastR  = e.r;
          lastDz = e.dz;
          doneCount++;
        end
      end else if (sb.size() > 0 && cycleCount > sb[0].startCycle &&
                   cycleCount < sb[0].doneAt) begin
        checkOutput("busy", DW'(busy), DW'(1));
      end
    end
  end

  task automatic waitDone(input int target);
    int n = 0;
    while (doneCount < target && n < DW + 20) begin
      @(posedge clk);
      n++;
    end
    if (doneCount < target) begin
      checkOutput("done_timeout", DW'(doneCount), DW'(target));
      sb.delete();
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] x, input logic [DW-1:0] y);
    int target;
    @(posedge clk);
    #1;
    checkOutput("r_hold", r, lastR);
    checkOutput("dz_hold", DW'(dz), DW'(lastDz));
    target = doneCount + 1;
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(refModel(x, y, cycleCount));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    waitDone(target);
  endtask

  // start held high with operands scrambled every cycle: only the first
  // pair counts, and the next accept is the cycle after done.
  task automatic holdStartTest(input logic [DW-1:0] x0, input logic [DW-1:0] y0,
                               input logic [DW-1:0] x1, input logic [DW-1:0] y1);
    int target;
    int n = 0;
    @(posedge clk);
    #1;
    target = doneCount + 1;
    a = x0;
    b = y0;
    start = 1'b1;
    sb.push_back(refModel(x0, y0, cycleCount));
    while (n < DW + 20) begin
      @(posedge clk);
      #1;
      if (doneCount >= target) break;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      n++;
    end
    if (doneCount < target) begin
      checkOutput("hold_done_timeout", DW'(doneCount), DW'(target));
      sb.delete();
      start = 1'b0;
    end else begin
      a = x1;
      b = y1;
      sb.push_back(refModel(x1, y1, cycleCount));
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone(target + 1);
    end
  endtask

  task automatic resetMidOpTest(input logic [DW-1:0] x, input logic [DW-1:0] y);
    @(posedge clk);
    #1;
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(refModel(x, y, cycleCount));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("rst_busy", DW'(busy), '0);
    checkOutput("rst_done", DW'(done), '0);
    checkOutput("rst_r", r, '0);
    checkOutput("rst_dz", DW'(dz), '0);
    sb.delete();
    lastR  = '0;
    lastDz = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    // Any done in this window has no pending entry and is flagged.
    repeat (DW + 10) @(posedge clk);
  endtask

  initial begin
    logic [DW-1:0] dirA[10];
    logic [DW-1:0] dirB[10];
    dirA = '{DW'(17), -DW'(17), DW'(17), -DW'(17), MINV, DW'(42), '0, MAXV, MINV, DW'(3)};
    dirB = '{DW'(5), DW'(5), -DW'(5), -DW'(5), '1, '0, DW'(7), MINV, DW'(1), DW'(100)};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", DW'(busy), '0);
    checkOutput("reset_done", DW'(done), '0);
    checkOutput("reset_r", r, '0);
    checkOutput("reset_dz", DW'(dz), '0);
    #2;
    rst = 1'b1;

    for (int i = 0; i < 10; i++) applyStimulus(dirA[i], dirB[i]);

    holdStartTest(DW'(29), DW'(6), -DW'(29), DW'(6));
    resetMidOpTest(DW'(1000), DW'(7));
    applyStimulus(-DW'(1000), DW'(7));

    for (int i = 0; i < 1000; i++) applyStimulus(randOperand(), randOperand());

    if (sb.size() != 0) checkOutput("scoreboard_empty", DW'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
